// File: rtl/vend_pkg.sv
// Shared encodings for the vending credit path: FSM states, coin values and change-coin codes.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam int unsigned COIN_5_VAL  = 5;
  localparam int unsigned COIN_10_VAL = 10;
  localparam int unsigned COIN_25_VAL = 25;

  localparam logic [1:0] CC_NONE = 2'b00;
  localparam logic [1:0] CC_5    = 2'b01;
  localparam logic [1:0] CC_10   = 2'b10;
  localparam logic [1:0] CC_25   = 2'b11;

  function automatic int unsigned coin_code_value(input logic [1:0] code);
    case (code)
      CC_5:    return COIN_5_VAL;
      CC_10:   return COIN_10_VAL;
      CC_25:   return COIN_25_VAL;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_credit_ctrl_change_picker.sv
// Greedy change selection: largest coin not exceeding the credit (5c floor).
module change_picker
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_code,
  output logic [CREDIT_W-1:0] o_value
);

  localparam logic [CREDIT_W-1:0] L_25 = CREDIT_W'(COIN_25_VAL);
  localparam logic [CREDIT_W-1:0] L_10 = CREDIT_W'(COIN_10_VAL);
  localparam logic [CREDIT_W-1:0] L_5  = CREDIT_W'(COIN_5_VAL);

  always_comb begin
    o_code  = CC_5;
    o_value = L_5;
    if (i_credit >= L_25) begin
      o_code  = CC_25;
      o_value = L_25;
    end else if (i_credit >= L_10) begin
      o_code  = CC_10;
      o_value = L_10;
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit/vend controller: accumulates debounced coin pulses, vends at PRICE and pays change
// one coin per valid/ready handshake.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE      = 75,
  parameter int unsigned MAX_CREDIT = 200,
  parameter int unsigned CREDIT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                coin_25,
  input  logic                sel,
  input  logic                cancel,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] L_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   L_MAX   = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_coin_reject;

  logic                w_coin_any;
  logic                w_coin_extra;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_fits;
  logic [1:0]          w_pick_code;
  logic [CREDIT_W-1:0] w_pick_val;

  change_picker #(
    .CREDIT_W(CREDIT_W)
  ) u_picker (
    .i_credit(r_credit),
    .o_code  (w_pick_code),
    .o_value (w_pick_val)
  );

  // Only the highest-value coin in a cycle is a candidate; any lower ones are extras.
  always_comb begin
    w_coin_any   = coin_25 | coin_10 | coin_5;
    w_coin_extra = coin_25 ? (coin_10 | coin_5) : (coin_10 & coin_5);
    w_coin_val   = '0;
    if (coin_25)      w_coin_val = CREDIT_W'(COIN_25_VAL);
    else if (coin_10) w_coin_val = CREDIT_W'(COIN_10_VAL);
    else if (coin_5)  w_coin_val = CREDIT_W'(COIN_5_VAL);
    w_sum  = {1'b0, r_credit} + {1'b0, w_coin_val};
    w_fits = (w_sum <= L_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_coin_reject <= 1'b0;
      case (r_state)
        S_IDLE, S_COLLECT: begin
          // sel/cancel act on pre-coin credit; a coin arriving alongside them is refused.
          if (cancel || sel) begin
            r_coin_reject <= w_coin_any;
            if (cancel) begin
              if (r_state == S_COLLECT) r_state <= S_CHANGE;
            end else if (r_credit >= L_PRICE) begin
              r_state  <= S_DISPENSE;
              r_credit <= r_credit - L_PRICE;
            end
          end else if (w_coin_any) begin
            r_coin_reject <= w_coin_extra | ~w_fits;
            if (w_fits) begin
              r_credit <= w_sum[CREDIT_W-1:0];
              r_state  <= S_COLLECT;
            end
          end
        end
        S_DISPENSE: begin
          r_coin_reject <= w_coin_any;
          r_state       <= (r_credit != '0) ? S_CHANGE : S_IDLE;
        end
        S_CHANGE: begin
          r_coin_reject <= w_coin_any;
          if (change_ready) begin
            r_credit <= r_credit - w_pick_val;
            if (r_credit == w_pick_val) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign credit       = r_credit;
  assign dispense     = (r_state == S_DISPENSE);
  assign change_valid = (r_state == S_CHANGE);
  assign change_coin  = (r_state == S_CHANGE) ? w_pick_code : CC_NONE;
  assign busy         = (r_state == S_DISPENSE) || (r_state == S_CHANGE);
  assign coin_reject  = r_coin_reject;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a rule-level model.
module tb_vend_credit_ctrl;

  localparam int PRICE      = 75;
  localparam int MAX_CREDIT = 200;
  localparam int CREDIT_W   = 8;

  localparam logic [5:0] V_C5  = 6'b000001;
  localparam logic [5:0] V_C10 = 6'b000010;
  localparam logic [5:0] V_C25 = 6'b000100;
  localparam logic [5:0] V_SEL = 6'b001000;
  localparam logic [5:0] V_CAN = 6'b010000;
  localparam logic [5:0] V_RDY = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_5 = 1'b0, coin_10 = 1'b0, coin_25 = 1'b0;
  logic sel = 1'b0, cancel = 1'b0, change_ready = 1'b0;
  logic [CREDIT_W-1:0] credit;
  logic dispense, coin_reject, change_valid, busy;
  logic [1:0] change_coin;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: credit in cents, whether a vend strobe or change payout is in progress.
  int m_credit   = 0;
  bit m_vending  = 1'b0;
  bit m_paying   = 1'b0;
  bit m_rej      = 1'b0;

  vend_credit_ctrl #(
    .PRICE(PRICE),
    .MAX_CREDIT(MAX_CREDIT),
    .CREDIT_W(CREDIT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coin_5(coin_5),
    .coin_10(coin_10),
    .coin_25(coin_25),
    .sel(sel),
    .cancel(cancel),
    .change_ready(change_ready),
    .credit(credit),
    .dispense(dispense),
    .coin_reject(coin_reject),
    .change_valid(change_valid),
    .change_coin(change_coin),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int greedy(input int c);
    if (c >= 25) return 25;
    if (c >= 10) return 10;
    return 5;
  endfunction

  function automatic int coin_code(input int v);
    case (v)
      25: return 3;
      10: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic void model_step();
    int ncoins;
    int best;
    bit rej;
    ncoins = int'(coin_5) + int'(coin_10) + int'(coin_25);
    best   = coin_25 ? 25 : (coin_10 ? 10 : (coin_5 ? 5 : 0));
    rej    = 1'b0;
    if (reset) begin
      m_credit  = 0;
      m_vending = 1'b0;
      m_paying  = 1'b0;
    end else if (m_vending) begin
      m_vending = 1'b0;
      m_paying  = (m_credit > 0);
      rej       = (ncoins > 0);
    end else if (m_paying) begin
      rej = (ncoins > 0);
      if (change_ready) begin
        m_credit -= greedy(m_credit);
        if (m_credit == 0) m_paying = 1'b0;
      end
    end else if (sel || cancel) begin
      rej = (ncoins > 0);
      if (cancel) begin
        if (m_credit > 0) m_paying = 1'b1;
      end else if (m_credit >= PRICE) begin
        m_credit -= PRICE;
        m_vending = 1'b1;
      end
    end else if (ncoins > 0) begin
      if (m_credit + best <= MAX_CREDIT) begin
        m_credit += best;
        rej = (ncoins > 1);
      end else begin
        rej = 1'b1;
      end
    end
    m_rej = reset ? 1'b0 : rej;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("credit", int'(credit), m_credit);
      chk("dispense", int'(dispense), int'(m_vending));
      chk("change_valid", int'(change_valid), int'(m_paying));
      chk("change_coin", int'(change_coin), m_paying ? coin_code(greedy(m_credit)) : 0);
      chk("busy", int'(busy), int'(m_vending | m_paying));
      chk("coin_reject", int'(coin_reject), int'(m_rej));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc(input logic [5:0] v);
    coin_5       = v[0];
    coin_10      = v[1];
    coin_25      = v[2];
    sel          = v[3];
    cancel       = v[4];
    change_ready = v[5];
    tick();
  endtask

  // Hold ready high until the payout finishes; bounded so a stuck payout still reaches the summary.
  task automatic drain(output int ncoins, output int n25);
    ncoins = 0;
    n25    = 0;
    for (int i = 0; i < 40 && change_valid; i++) begin
      ncoins++;
      if (change_coin == 2'b11) n25++;
      cyc(V_RDY);
    end
    chk("drain_done", int'(change_valid), 0);
    chk("drain_credit", int'(credit), 0);
  endtask

  initial begin
    int nc, n25;
    reset = 1'b1;
    cyc(6'b0);
    chk_en = 1'b1;
    cyc(6'b0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(change_valid), 0);
    chk("rst_dispense", int'(dispense), 0);
    reset = 1'b0;
    cyc(6'b0);

    // Exact price: vend with no change.
    cyc(V_C25); chk("t1_c25", int'(credit), 25);
    cyc(V_C25); chk("t1_c50", int'(credit), 50);
    cyc(V_C25); chk("t1_c75", int'(credit), 75);
    cyc(V_SEL);
    chk("t1_disp", int'(dispense), 1);
    chk("t1_credit", int'(credit), 0);
    cyc(6'b0);
    chk("t1_disp_off", int'(dispense), 0);
    chk("t1_no_change", int'(change_valid), 0);
    chk("t1_idle", int'(busy), 0);

    // Overpay: one 25c change coin.
    repeat (4) cyc(V_C25);
    chk("t2_c100", int'(credit), 100);
    cyc(V_SEL);
    chk("t2_disp", int'(dispense), 1);
    chk("t2_credit", int'(credit), 25);
    cyc(6'b0);
    chk("t2_valid", int'(change_valid), 1);
    chk("t2_coin", int'(change_coin), 3);
    cyc(V_RDY);
    chk("t2_credit0", int'(credit), 0);
    chk("t2_valid0", int'(change_valid), 0);

    // Cancel with backpressure: coin held stable, then 10 and 5 paid.
    cyc(V_C10);
    cyc(V_C5);
    cyc(V_CAN);
    chk("t3_valid", int'(change_valid), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(6'b0);
      chk("t3_hold", int'(change_coin), 2);
      chk("t3_hold_credit", int'(credit), 15);
    end
    cyc(V_RDY);
    chk("t3_after10", int'(credit), 5);
    chk("t3_coin5", int'(change_coin), 1);
    cyc(V_RDY);
    chk("t3_credit0", int'(credit), 0);
    chk("t3_valid0", int'(change_valid), 0);

    // Simultaneous coins and ceiling rejection.
    cyc(V_C25 | V_C10);
    chk("t4_multi_credit", int'(credit), 25);
    chk("t4_multi_rej", int'(coin_reject), 1);
    cyc(6'b0);
    chk("t4_rej_pulse", int'(coin_reject), 0);
    repeat (6) cyc(V_C25);
    cyc(V_C10);
    cyc(V_C5);
    chk("t4_c190", int'(credit), 190);
    cyc(V_C25);
    chk("t4_ceiling_credit", int'(credit), 190);
    chk("t4_ceiling_rej", int'(coin_reject), 1);
    cyc(V_CAN);
    drain(nc, n25);
    chk("t4_ncoins", nc, 9);

    // Insufficient credit, then sel&cancel together: cancel wins.
    cyc(V_C25); cyc(V_C25);
    cyc(V_SEL);
    chk("t5_no_disp", int'(dispense), 0);
    chk("t5_c50", int'(credit), 50);
    cyc(V_C25); cyc(V_C25);
    cyc(V_SEL | V_CAN);
    chk("t5_no_disp2", int'(dispense), 0);
    chk("t5_cancel_valid", int'(change_valid), 1);
    chk("t5_c100", int'(credit), 100);
    drain(nc, n25);
    chk("t5_ncoins", nc, 4);
    chk("t5_n25", n25, 4);

    // Reset during payout.
    cyc(V_C25);
    cyc(V_CAN);
    chk("t6_in_change", int'(change_valid), 1);
    reset = 1'b1;
    cyc(6'b0);
    chk("t6_credit", int'(credit), 0);
    chk("t6_valid", int'(change_valid), 0);
    chk("t6_busy", int'(busy), 0);
    reset = 1'b0;
    cyc(6'b0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] v;
      v[0] = ($urandom_range(0, 3) == 0);
      v[1] = ($urandom_range(0, 3) == 0);
      v[2] = ($urandom_range(0, 2) == 0);
      v[3] = ($urandom_range(0, 7) == 0);
      v[4] = ($urandom_range(0, 15) == 0);
      v[5] = ($urandom_range(0, 1) == 0);
      reset = ($urandom_range(0, 299) == 0);
      cyc(v);
    end
    reset = 1'b0;
    cyc(6'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
